// File: rtl/bin_cnt_pkg.sv
// bin_cnt_pkg: shared FSM state type and default counter width for the binary counter.
package bin_cnt_pkg;
    typedef enum logic [0:0] {S_IDLE, S_COUNT} state_t;
    localparam int DEFAULT_SIZE = 4;
endpackage

// File: rtl/bin_cnt_datapath.sv
// bin_cnt_datapath: count register plus incrementer, wraps modulo 2^size.
module bin_cnt_datapath #(
    parameter int size = bin_cnt_pkg::DEFAULT_SIZE
) (
    input  logic            enable_DP,
    input  logic            clk,
    input  logic            rst,
    output logic [size-1:0] count
);
    logic [size-1:0] count_q, count_d;
    always_comb count_d = enable_DP ? count_q + size'(1) : count_q;
    always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
    assign count = count_q;
endmodule

// File: rtl/binary_counter_part_rtl_spec.sv
// binary_counter_part_rtl_spec: FSM control unit driving a counter datapath.
// Optional registered wrap pulse output when BIN_CNT_WRAP_FLAG_EN is defined.
module binary_counter_part_rtl_spec
    import bin_cnt_pkg::*;
#(
    parameter int size = DEFAULT_SIZE
) (
    output logic [size-1:0] count,
    input  logic            enable,
    input  logic            clk,
    input  logic            rst
`ifdef BIN_CNT_WRAP_FLAG_EN
    ,
    output logic            wrap
`endif
);
    state_t state_q, state_d;
    logic   enable_DP;
    always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
    // Mealy strobe: the increment follows enable in both states, no added latency
    always_comb begin
        state_d   = state_q;
        enable_DP = enable;
        if (state_q == S_IDLE) state_d = enable ? S_COUNT : S_IDLE;
        else                   state_d = enable ? S_COUNT : S_IDLE;
    end
    bin_cnt_datapath #(.size(size)) u_dp (
        .enable_DP(enable_DP),
        .clk      (clk),
        .rst      (rst),
        .count    (count)
    );
`ifdef BIN_CNT_WRAP_FLAG_EN
    logic wrap_q, wrap_d;
    always_comb wrap_d = enable_DP && (count == {size{1'b1}});
    always_ff @(posedge clk) wrap_q <= rst ? 1'b0 : wrap_d;
    assign wrap = wrap_q;
`endif
endmodule

// File: tb/tb_binary_counter_part_rtl_spec.sv
// tb_binary_counter_part_rtl_spec: table-driven directed bench for the binary counter.
module tb_binary_counter_part_rtl_spec;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] count;
`ifdef BIN_CNT_WRAP_FLAG_EN
    logic       wrap;
`endif
    int checks = 0;
    int failures = 0;

    binary_counter_part_rtl_spec #(.size(4)) dut (
        .count (count),
        .enable(enable),
        .clk   (clk),
        .rst   (rst)
`ifdef BIN_CNT_WRAP_FLAG_EN
        ,
        .wrap  (wrap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] cnt;
        logic       wr;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [3:0] cnt, input logic wr);
        vec_t v;
        v.r = r; v.e = e; v.cnt = cnt; v.wr = wr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] cnt, input logic wr);
        checks++;
        if (count !== cnt) begin
            failures++;
            $display("FAIL %s count got=%0d want=%0d at t=%0t", name, count, cnt, $time);
        end
`ifdef BIN_CNT_WRAP_FLAG_EN
        checks++;
        if (wrap !== wr) begin
            failures++;
            $display("FAIL %s wrap got=%0b want=%0b at t=%0t", name, wrap, wr, $time);
        end
`else
        if (wr === 1'bx) $display("unexpected x in wrap expectation");
`endif
    endtask

    task automatic edge_check(input string name, input logic [3:0] cnt, input logic wr);
        @(posedge clk);
        #1;
        chk(name, cnt, wr);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        add(1, 0, 0, 0);
        add(0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) add(0, 1, 4'(i), 0);
        add(0, 1, 0, 1);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        add(0, 1, 1, 0);
        add(0, 1, 2, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 4'(i), 0);
        foreach (vecs[i]) begin
            rst = vecs[i].r;
            enable = vecs[i].e;
            edge_check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].wr);
        end
        // enable pulsed between edges but low at the edge: count must hold
        enable = 1'b0;
        #2 enable = 1'b1;
        #2 enable = 1'b0;
        edge_check("glitch_low", 5, 0);
        // enable low then high before the edge: only the edge value counts
        #2 enable = 1'b1;
        edge_check("late_high", 6, 0);
        rst = 1'b1;
        enable = 1'b1;
        edge_check("rst_prio", 0, 0);
        rst = 1'b0;
        edge_check("resume", 1, 0);
        edge_check("resume2", 2, 0);
        enable = 1'b0;
        edge_check("hold", 2, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
